// File: rtl/key_state_decoder.sv
// PS/2 set-2 scan-code decoder: tracks make/break prefixes and keeps a held-level
// bit plus one-cycle press/release pulses for each mapped key.
module key_state_decoder #(
  parameter int unsigned NUM_KEYS       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [7:0]          scanCode,
  input  logic                scanValid,
  input  logic                scanError,
  input  logic                clearAll,
  output logic [NUM_KEYS-1:0] inputStateStorage,
  output logic [NUM_KEYS-1:0] keyPressPulse,
  output logic [NUM_KEYS-1:0] keyReleasePulse
);

  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned MAP_W    = 16;
  localparam logic [7:0]  CODE_BRK = 8'hF0;
  localparam logic [7:0]  CODE_EXT = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREAK,
    ST_EXT,
    ST_EXT_BREAK
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_KEYS-1:0]   key_q, key_d;
  logic [NUM_KEYS-1:0]   press_q, press_d;
  logic [NUM_KEYS-1:0]   release_q, release_d;
  logic [NUM_KEYS-1:0]   hit_c;

  // One-hot key position for a scan code; zero when the code is not mapped.
  function automatic logic [MAP_W-1:0] map_code(input logic [7:0] code);
    case (code)
      8'h29:   map_code = 16'h0001;
      8'h5D:   map_code = 16'h0002;
      8'h2D:   map_code = 16'h0004;
      8'h1C:   map_code = 16'h0008;
      8'h1D:   map_code = 16'h0010;
      8'h1B:   map_code = 16'h0020;
      8'h24:   map_code = 16'h0040;
      8'h23:   map_code = 16'h0080;
      8'h2B:   map_code = 16'h0100;
      8'h2C:   map_code = 16'h0200;
      8'h34:   map_code = 16'h0400;
      8'h35:   map_code = 16'h0800;
      8'h33:   map_code = 16'h1000;
      8'h3C:   map_code = 16'h2000;
      8'h3B:   map_code = 16'h4000;
      8'h42:   map_code = 16'h8000;
      default: map_code = 16'h0000;
    endcase
  endfunction

  assign hit_c = NUM_KEYS'(map_code(scanCode));

  // Next-state decode: clearAll beats a byte, a bad byte only resets the prefix.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    press_d   = '0;
    release_d = '0;
    if (clearAll) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      key_d     = '0;
      release_d = key_q;
    end else if (scanValid) begin
      cnt_d = '0;
      if (scanError) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (scanCode == CODE_BRK) begin
              state_d = ST_BREAK;
            end else if (scanCode == CODE_EXT) begin
              state_d = ST_EXT;
            end else begin
              key_d   = key_q | hit_c;
              press_d = hit_c & ~key_q;
            end
          end
          ST_BREAK: begin
            state_d   = ST_IDLE;
            key_d     = key_q & ~hit_c;
            release_d = hit_c & key_q;
          end
          ST_EXT: begin
            state_d = (scanCode == CODE_BRK) ? ST_EXT_BREAK : ST_IDLE;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      // A stalled prefix is dropped; the counter never runs past its limit.
      if (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      key_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign inputStateStorage = key_q;
  assign keyPressPulse     = press_q;
  assign keyReleasePulse   = release_q;

endmodule

// File: tb/tb_key_state_decoder.sv
// Directed and random bench for key_state_decoder, checked against a byte-stream
// reference model that tracks held keys and pending prefixes as plain flags.
module tb_key_state_decoder;

  localparam int unsigned NK = 16;
  localparam int unsigned TO = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic [7:0]    scan_code;
  logic          scan_valid;
  logic          scan_error;
  logic          clear_all;
  logic [NK-1:0] storage;
  logic [NK-1:0] press;
  logic [NK-1:0] rel;

  key_state_decoder #(
    .NUM_KEYS      (NK),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .scanCode         (scan_code),
    .scanValid        (scan_valid),
    .scanError        (scan_error),
    .clearAll         (clear_all),
    .inputStateStorage(storage),
    .keyPressPulse    (press),
    .keyReleasePulse  (rel)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  byte unsigned key_codes [NK] = '{8'h29, 8'h5D, 8'h2D, 8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23,
                                   8'h2B, 8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};

  // Reference state: which keys are down, whether an E0 and/or F0 prefix is pending.
  logic [NK-1:0] m_held, m_press, m_rel;
  bit            m_ext, m_brk;
  int            m_idle;

  function automatic int lookup(byte unsigned c);
    for (int i = 0; i < int'(NK); i++)
      if (key_codes[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_held = '0; m_press = '0; m_rel = '0;
    m_ext = 0; m_brk = 0; m_idle = 0;
  endtask

  task automatic model_step(bit v, byte unsigned c, bit e, bit clr);
    int k;
    m_press = '0;
    m_rel   = '0;
    k = lookup(c);
    if (clr) begin
      m_rel = m_held; m_held = '0;
      m_ext = 0; m_brk = 0; m_idle = 0;
    end else if (v) begin
      m_idle = 0;
      if (e) begin
        m_ext = 0; m_brk = 0;
      end else if (m_brk) begin
        if (!m_ext && k >= 0 && m_held[k]) begin
          m_held[k] = 1'b0; m_rel[k] = 1'b1;
        end
        m_ext = 0; m_brk = 0;
      end else if (m_ext) begin
        if (c == 8'hF0) m_brk = 1;
        else m_ext = 0;
      end else if (c == 8'hF0) begin
        m_brk = 1;
      end else if (c == 8'hE0) begin
        m_ext = 1;
      end else if (k >= 0 && !m_held[k]) begin
        m_held[k] = 1'b1; m_press[k] = 1'b1;
      end
    end else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle >= int'(TO)) begin
        m_ext = 0; m_brk = 0; m_idle = 0;
      end
    end
  endtask

  task automatic check(string tag, logic [NK-1:0] obs, logic [NK-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("storage", storage, m_held);
    check("press", press, m_press);
    check("release", rel, m_rel);
    check("press_and_release", press & rel, '0);
  endtask

  task automatic cycle(bit v, byte unsigned c, bit e, bit clr);
    scan_valid = v; scan_code = c; scan_error = e; clear_all = clr;
    @(posedge clk);
    model_step(v, c, e, clr);
    #1;
    scan_valid = 1'b0; scan_error = 1'b0; clear_all = 1'b0;
    check_all();
  endtask

  task automatic send(byte unsigned c);
    cycle(1'b1, c, 1'b0, 1'b0);
  endtask

  initial begin
    int r, gap, sel;
    byte unsigned c;
    resetn = 1'b0; scan_code = 8'h00; scan_valid = 1'b0; scan_error = 1'b0; clear_all = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    resetn = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Make and break of Space.
    send(8'h29);
    check("make29_bit", storage, NK'(16'h0001));
    check("make29_pulse", press, NK'(16'h0001));
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("make29_pulse_width", press, '0);
    send(8'hF0);
    send(8'h29);
    check("break29_pulse", rel, NK'(16'h0001));
    check("break29_bit", storage, '0);

    // Extended sequences never touch the vector; then 1C decodes from idle, repeats are silent.
    send(8'hE0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h1C);
    check("ext_storage", storage, '0);
    send(8'h1C);
    check("make1c_pulse", press, NK'(16'h0008));
    send(8'h1C);
    check("repeat1c_nopulse", press, '0);
    send(8'h1C);
    check("repeat1c_bit", storage, NK'(16'h0008));

    // Break of an unheld key, and an errored byte dropping the prefix.
    send(8'hF0); send(8'h42);
    check("break_unheld", rel, '0);
    send(8'hF0);
    cycle(1'b1, 8'h29, 1'b1, 1'b0);
    send(8'h1C);
    check("err_then_make", storage, NK'(16'h0008));

    // Stale break prefix times out; 2D is then a make.
    send(8'hF0);
    repeat (TO) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    send(8'h2D);
    check("timeout_make2d", storage, NK'(16'h000C));

    // clearAll wins over a simultaneous byte.
    send(8'hF0); send(8'h2D);
    send(8'hF0); send(8'h1C);
    send(8'h29); send(8'h42);
    cycle(1'b1, 8'h2D, 1'b0, 1'b1);
    check("clear_vector", storage, '0);
    check("clear_release", rel, NK'(16'h8001));

    // Asynchronous reset mid-prefix discards the pending F0.
    send(8'h5D);
    send(8'hF0);
    resetn = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    resetn = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    send(8'h5D);
    check("reset_then_make5d", storage, NK'(16'h0002));

    // Random traffic biased toward prefixes and mapped codes.
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        cycle(1'($urandom_range(0, 1)), 8'h29, 1'b0, 1'b1);
      end else if (r < 5) begin
        gap = int'(TO) - 2 + int'($urandom_range(0, 3));
        repeat (gap) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      end else begin
        sel = int'($urandom_range(0, 9));
        if (sel < 2) c = 8'hF0;
        else if (sel == 2) c = 8'hE0;
        else if (sel == 3) c = 8'($urandom_range(0, 255));
        else c = key_codes[$urandom_range(0, NK - 1)];
        cycle(1'($urandom_range(0, 1)), c, ($urandom_range(0, 19) == 0), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
